// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage: word width, reset PC,
// the PC alignment mask and the fetch FSM state encoding.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_W-1:0] ADDR_ALIGN = 32'hFFFF_FFFC;

   typedef enum logic {
      ST_RESET,
      ST_RUN
   } fetch_state_t;

   // Redirect targets arrive byte-addressed; fetch only ever uses word addresses.
   function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
      return pc & ADDR_ALIGN;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch stage's memory request port, redirect input and
// decode handshake; master is the fetch unit, slave is its environment.
interface ifu_fetch_if;
   import mips_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [WORD_W-1:0] imem_rdata;
   logic              redirect;
   logic [WORD_W-1:0] redirect_pc;
   logic              ins_valid;
   logic              ins_ready;
   logic [WORD_W-1:0] ins_out;
   logic [WORD_W-1:0] ins_pc;

   modport master (
      output imem_req, imem_addr, ins_valid, ins_out, ins_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ins_ready
   );

   modport slave (
      input  imem_req, imem_addr, ins_valid, ins_out, ins_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ins_ready
   );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Synchronous show-ahead FIFO holding {pc, instruction} pairs for decode.
// Flush overrides push and pop in the same cycle.
module ifu_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: credit-limited word requests to a variable-latency
// memory, in-order buffering for decode, and redirect with old-path squashing.
module ifu_fetch
   import mips_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_state_t        state;
   logic [WORD_W-1:0]   fetch_pc;
   logic [CW-1:0]       outstanding;
   logic [CW-1:0]       outstanding_nxt;
   logic [CW-1:0]       drop;
   logic [CW-1:0]       count;
   logic [CW:0]         in_use;
   logic [WORD_W-1:0]   tag_mem [DEPTH];
   logic [PW-1:0]       tag_wr;
   logic [PW-1:0]       tag_rd;
   logic                grant;
   logic                rsp;
   logic                keep;
   logic                pop;
   logic [2*WORD_W-1:0] head;

   // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
   assign in_use        = {1'b0, count} + {1'b0, outstanding};
   assign bus.imem_req  = (state == ST_RUN) && (in_use < (CW+1)'(DEPTH));
   assign bus.imem_addr = fetch_pc;

   assign grant = bus.imem_req && bus.imem_gnt;
   assign rsp   = bus.imem_rvalid && (outstanding != '0);
   assign keep  = rsp && (drop == '0) && !bus.redirect;
   assign pop   = bus.ins_valid && bus.ins_ready;

   assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RESET;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         state       <= ST_RUN;
         outstanding <= outstanding_nxt;
         if (grant) tag_wr <= tag_wr + PW'(1);
         if (rsp)   tag_rd <= tag_rd + PW'(1);
         // Everything still in flight after a redirect belongs to the old path.
         if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
            drop     <= outstanding_nxt;
         end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (rsp && (drop != '0)) drop <= drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant) tag_mem[tag_wr] <= fetch_pc;
   end

   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.redirect),
      .push  (keep),
      .din   ({tag_mem[tag_rd], bus.imem_rdata}),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   assign bus.ins_valid = (count != '0);
   assign bus.ins_out   = bus.ins_valid ? head[WORD_W-1:0]        : '0;
   assign bus.ins_pc    = bus.ins_valid ? head[2*WORD_W-1:WORD_W] : '0;

   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
      bus.imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by randomized
// traffic, checked against a program-order model of what decode should see.
module tb_ifu_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ifu_fetch_if bus();

   ifu_fetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int lat_lo = 1;
   int lat_hi = 1;
   int delivered = 0;
   int grants = 0;
   int first_valid;
   int base;

   logic [31:0] mq[$];
   int          mdue[$];
   logic [31:0] exp_pc = RESET_PC;
   bit          first_seen = 1'b0;
   logic [31:0] first_pc = '0;
   bit          hold_pending = 1'b0;
   logic [31:0] held_pc = '0;
   logic [31:0] held_out = '0;

   bit          r_rst, r_gnt, r_rdy, r_red;
   logic [31:0] r_pc;

   // Memory content is a fixed scramble of the address, so any word identifies its PC.
   function automatic logic [31:0] ins_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample outputs at the falling edge, drive inputs, update the model.
   task automatic applyStimulus(input bit rst_v, input bit gnt_v, input bit rdy_v,
                                input bit red_v, input logic [31:0] red_pc);
      logic        s_req, s_valid, rv;
      logic [31:0] s_addr, s_out, s_pc;
      @(negedge clk);
      s_req   = bus.imem_req;
      s_addr  = bus.imem_addr;
      s_valid = bus.ins_valid;
      s_out   = bus.ins_out;
      s_pc    = bus.ins_pc;
      if (hold_pending) begin
         checkOutput("hold_valid", {31'b0, s_valid}, 32'd1);
         checkOutput("hold_pc", s_pc, held_pc);
         checkOutput("hold_ins", s_out, held_out);
      end
      rv = !rst_v && (mq.size() > 0) && (mdue[0] <= cyc);
      rst             = rst_v;
      bus.imem_gnt    = gnt_v;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? ins_of(mq[0]) : $urandom;
      bus.ins_ready   = rdy_v;
      bus.redirect    = red_v;
      bus.redirect_pc = red_pc;
      if (rst_v) begin
         mq.delete();
         mdue.delete();
         exp_pc     = RESET_PC;
         first_seen = 1'b0;
      end else begin
         if (rv) begin
            void'(mq.pop_front());
            void'(mdue.pop_front());
         end
         if (s_req && gnt_v) begin
            mq.push_back(s_addr);
            mdue.push_back(cyc + $urandom_range(lat_hi, lat_lo));
            grants++;
            checkOutput("addr_align", {30'b0, s_addr[1:0]}, 32'd0);
            checkOutput("mem_credit", {31'b0, mq.size() <= DEPTH}, 32'd1);
         end
         if (s_valid && rdy_v && !red_v) begin
            checkOutput("ins_pc", s_pc, exp_pc);
            checkOutput("ins_out", s_out, ins_of(exp_pc));
            if (!first_seen) begin
               first_seen = 1'b1;
               first_pc   = s_pc;
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (red_v) begin
            exp_pc     = red_pc & 32'hFFFF_FFFC;
            first_seen = 1'b0;
         end
      end
      hold_pending = !rst_v && !red_v && s_valid && !rdy_v;
      held_pc      = s_pc;
      held_out     = s_out;
      @(posedge clk);
      cyc++;
   endtask

   task automatic runUntilFirst(input string tag, input logic [31:0] want);
      for (int i = 0; i < 30 && !first_seen; i++) applyStimulus(0, 1, 1, 0, '0);
      checkOutput({tag, "_seen"}, {31'b0, first_seen}, 32'd1);
      checkOutput({tag, "_pc"}, first_pc, want);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req"}, {31'b0, bus.imem_req}, 32'd0);
      checkOutput({tag, "_addr"}, bus.imem_addr, RESET_PC);
      checkOutput({tag, "_valid"}, {31'b0, bus.ins_valid}, 32'd0);
      checkOutput({tag, "_ins"}, bus.ins_out, 32'd0);
      checkOutput({tag, "_pc"}, bus.ins_pc, 32'd0);
   endtask

   initial begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.ins_ready   = 1'b0;

      // Reset values.
      repeat (3) applyStimulus(1, 0, 0, 0, '0);
      #1 checkResetOutputs("reset");

      // Start-up latency and one-per-cycle streaming with single-cycle memory.
      delivered   = 0;
      first_valid = -1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, 1, 0, '0);
         #1 if (first_valid < 0 && bus.ins_valid) first_valid = i + 1;
      end
      checkOutput("startup_latency", first_valid, 32'd3);
      checkOutput("stream_rate", delivered, 32'd9);

      // Decode stalled: credit stops requests at DEPTH, then resumes after a pop.
      repeat (2) applyStimulus(1, 0, 0, 0, '0);
      grants    = 0;
      delivered = 0;
      repeat (10) applyStimulus(0, 1, 0, 0, '0);
      checkOutput("stall_grants", grants, DEPTH);
      #1 checkOutput("stall_req_low", {31'b0, bus.imem_req}, 32'd0);
      applyStimulus(0, 1, 1, 0, '0);
      #1 checkOutput("req_after_pop", {31'b0, bus.imem_req}, 32'd1);
      repeat (10) applyStimulus(0, 1, 1, 0, '0);
      checkOutput("stall_drain", {31'b0, delivered >= 4}, 32'd1);

      // Latency 3 with two words in flight, then redirect.
      repeat (2) applyStimulus(1, 0, 0, 0, '0);
      lat_lo = 3;
      lat_hi = 3;
      grants = 0;
      applyStimulus(0, 0, 0, 0, '0);
      repeat (2) applyStimulus(0, 1, 0, 0, '0);
      checkOutput("inflight_grants", grants, 32'd2);
      applyStimulus(0, 0, 0, 1, 32'h0000_0100);
      #1 checkOutput("redir_addr", bus.imem_addr, 32'h0000_0100);
      lat_lo = 1;
      lat_hi = 1;
      runUntilFirst("redir_100", 32'h0000_0100);

      // Unaligned redirect target.
      applyStimulus(0, 1, 1, 1, 32'h0000_0203);
      #1 checkOutput("unaligned_addr", bus.imem_addr, 32'h0000_0200);
      runUntilFirst("redir_200", 32'h0000_0200);

      // Redirect coinciding with grant, response and decode transfer.
      repeat (5) applyStimulus(0, 1, 1, 0, '0);
      applyStimulus(0, 1, 1, 1, 32'h0000_0400);
      #1 checkOutput("redir_flush_valid", {31'b0, bus.ins_valid}, 32'd0);
      runUntilFirst("redir_400", 32'h0000_0400);

      // Fetch address wraps at the top of the address space.
      applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC);
      #1 checkOutput("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 1, 0, '0);
      #1 checkOutput("wrap_zero", bus.imem_addr, 32'h0000_0000);
      runUntilFirst("wrap_first", 32'hFFFF_FFFC);
      repeat (5) applyStimulus(0, 1, 1, 0, '0);

      // Reset in the middle of a stream.
      applyStimulus(1, 1, 1, 0, '0);
      #1 checkResetOutputs("mid_reset");
      runUntilFirst("restart", RESET_PC);

      // Randomized traffic.
      lat_lo = 1;
      lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(199, 0) == 0);
         r_gnt = ($urandom_range(9, 0) < 7);
         r_rdy = ($urandom_range(9, 0) < 6);
         r_red = !r_rst && ($urandom_range(39, 0) == 0);
         r_pc  = $urandom;
         if ($urandom_range(3, 0) != 0) r_pc = r_pc & 32'h0000_0FFF;
         applyStimulus(r_rst, r_gnt, r_rdy, r_red, r_pc);
      end

      // Drain: the stream must settle back to near one instruction per cycle.
      lat_lo = 1;
      lat_hi = 1;
      base   = delivered;
      repeat (30) applyStimulus(0, 1, 1, 0, '0);
      checkOutput("drain_progress", {31'b0, (delivered - base) >= 15}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage directly upstream of decode/control. Holds the fetch PC and issues word requests to a variable-latency instruction memory through a request/grant port. Buffers returned instructions in a small in-order FIFO and hands them to decode with a valid/ready handshake. Accepts branch/jump redirects from downstream, flushing buffered and in-flight instructions from the old path.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered words (power of two, ≥2)
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of request, bits [1:0] always 0
- imem_gnt  in  1  memory accepts request this cycle (transfer = req & gnt)
- imem_rvalid  in  1  response data valid, in order, ≥1 cycle after its grant
- imem_rdata  in  32  instruction word
- redirect  in  1  take new path this cycle
- redirect_pc  in  32  new fetch address, bits [1:0] ignored
- ins_valid  out  1  ins_out/ins_pc hold a valid instruction
- ins_ready  in  1  decode consumes (transfer = valid & ready)
- ins_out  out  32  instruction word
- ins_pc  out  32  address of ins_out

## Operation
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins_out=0, ins_pc=0.
- States: RESET (held while rst) → RUN (cycle after rst deasserts). No other states; rst in any cycle returns to RESET and discards everything.
- Credit: imem_req = RUN & (count + outstanding < DEPTH). imem_addr = fetch_pc. On grant, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC→0), outstanding++.
- Response: on imem_rvalid, outstanding--. If drop>0, drop-- and data discarded; else push {imem_rdata, pc tag} to FIFO. PC tag kept in a parallel tag queue per grant.
- Output: show-ahead FIFO; ins_valid = count>0; ins_out/ins_pc = head entry; pop on valid&ready. Push and pop same cycle allowed, count unchanged.
- Redirect: fetch_pc ← {redirect_pc[31:2],2'b00}; FIFO flushed; drop ← outstanding after this cycle's grant/response updates (grant in redirect cycle counts as old path; rvalid in redirect cycle discarded).
- Redirect and ins transfer same cycle: redirect wins, popped entry irrelevant, FIFO empty next cycle.
- Memory never sees more than DEPTH outstanding; response with outstanding=0 is a protocol error (assert in simulation, ignore in RTL).

## Timing
- imem_req/imem_addr registered-state derived, combinational only from count/outstanding/fetch_pc; no input→imem_req path.
- Redirect at cycle t: imem_addr=new PC at t+1; with gnt at t+1 and rvalid at t+2, ins_valid=1 at t+3.
- Steady state with single-cycle memory and ins_ready=1: one instruction per cycle.
- ins_ready=0: FIFO fills; imem_req drops when count+outstanding=DEPTH, reasserts the cycle after a pop.
- ins_out/ins_pc stable while ins_valid & !ins_ready, except on redirect or rst.

## Structure
- Shared package mips_pkg: WORD_W=32, RESET_PC default, ADDR_ALIGN mask, state encoding (RESET, RUN).
- Sub-module ifu_fifo: synchronous show-ahead FIFO, width 64 ({pc,ins}), DEPTH entries, push/pop/flush, count output; flush has priority over push and pop.
- Top holds fetch_pc, outstanding/drop counters, tag queue, FSM.

## Test plan
- Reset release, memory gnt=1 and rvalid one cycle later, ins_ready=1 → ins_pc sequence 0x0,0x4,0x8,… one per cycle from third cycle after reset.
- ins_ready=0 for 10 cycles, DEPTH=4 → exactly 4 grants, imem_req=0 thereafter; ready=1 → instructions 0x0..0xC delivered in order, no loss or duplicate.
- Memory latency 3, two requests in flight, redirect to 0x0000_0100 → both old responses dropped, next ins_pc=0x100.
- redirect_pc=0x0000_0203 → imem_addr=0x0000_0200, ins_pc=0x200.
- Redirect same cycle as gnt, rvalid and ins transfer → all old-path data discarded, ins_valid=0 next cycle, first new instruction from redirect_pc.
- fetch_pc=0xFFFF_FFFC → next imem_addr=0x0000_0000; rst mid-stream → next cycle outputs at reset values, fetch restarts at RESET_PC.
